mvau_weight_loader: RTL and testbench

- Write-side counterpart to the per-PE MVAU weight memories. It accepts a weight stream over a valid/ready handshake and produces registered write-enable, address and data strobes for PE parallel weight memory banks.
- Each bank holds WMEM_DEPTH words of SIMD*TW bits.
- Sits between the host/DMA weight stream and the weight memory write ports. Enables runtime weight reload instead of relying only on initialisation files.

---
 rtl/mvau_weight_loader.sv | 125 ++++++++++++
 tb/tb_mvau_weight_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvau_weight_loader.sv
// Weight-stream loader for the per-PE MVAU weight memories.
// Streams PE*WMEM_DEPTH words address-major/PE-minor into registered bank write strobes.
module mvau_weight_loader #(
  parameter int unsigned SIMD         = 2,
  parameter int unsigned TW           = 1,
  parameter int unsigned PE           = 2,
  parameter int unsigned WMEM_DEPTH   = 4,
  parameter int unsigned WMEM_ADDR_BW = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    start,
  input  logic                    in_v,
  input  logic [SIMD*TW-1:0]      in_wgt,
  output logic                    in_rdy,
  output logic [PE-1:0]           wmem_we,
  output logic [WMEM_ADDR_BW-1:0] wmem_addr,
  output logic [SIMD*TW-1:0]      wmem_wdata,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned PeW   = (PE > 1) ? $clog2(PE) : 1;
  localparam int unsigned AddrW = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1;
  localparam int unsigned DataW = SIMD * TW;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e r_state, w_state_d;
  logic [PeW-1:0]          r_pe_cnt, w_pe_cnt_d;
  logic [AddrW-1:0]        r_addr_cnt, w_addr_cnt_d;
  logic                    r_armed;
  logic [PE-1:0]           r_we;
  logic [WMEM_ADDR_BW-1:0] r_addr;
  logic [DataW-1:0]        r_wdata;

  logic          w_accept;
  logic          w_pe_last;
  logic          w_addr_last;
  logic [PE-1:0] w_onehot;

  assign w_accept    = in_v && (r_state == StLoad);
  assign w_pe_last   = (r_pe_cnt == PeW'(PE - 1));
  assign w_addr_last = (r_addr_cnt == AddrW'(WMEM_DEPTH - 1));

  always_comb begin
    w_onehot = '0;
    for (int p = 0; p < PE; p++) begin
      w_onehot[p] = (r_pe_cnt == PeW'(p));
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_pe_cnt_d   = r_pe_cnt;
    w_addr_cnt_d = r_addr_cnt;
    case (r_state)
      StIdle: begin
        // r_armed masks a start coinciding with the first edge after reset release
        if (start && r_armed) begin
          w_state_d    = StLoad;
          w_pe_cnt_d   = '0;
          w_addr_cnt_d = '0;
        end
      end
      StLoad: begin
        if (w_accept) begin
          if (w_pe_last) begin
            w_pe_cnt_d = '0;
            if (w_addr_last) begin
              w_state_d = StDone;
            end else begin
              w_addr_cnt_d = r_addr_cnt + AddrW'(1);
            end
          end else begin
            w_pe_cnt_d = r_pe_cnt + PeW'(1);
          end
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state    <= StIdle;
      r_pe_cnt   <= '0;
      r_addr_cnt <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pe_cnt   <= w_pe_cnt_d;
      r_addr_cnt <= w_addr_cnt_d;
      r_armed    <= 1'b1;
    end
  end

  // Address and data hold between writes; only the enable drops.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_we    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_accept ? w_onehot : '0;
      if (w_accept) begin
        r_addr  <= WMEM_ADDR_BW'(r_addr_cnt);
        r_wdata <= in_wgt;
      end
    end
  end

  assign in_rdy     = (r_state == StLoad);
  assign busy       = (r_state == StLoad);
  assign done       = (r_state == StDone);
  assign wmem_we    = r_we;
  assign wmem_addr  = r_addr;
  assign wmem_wdata = r_wdata;

endmodule

// File: tb/tb_mvau_weight_loader.sv
// Directed bench for mvau_weight_loader: default instance plus a PE=1 sweep instance,
// checked every cycle against a beat-index model and against hand-computed strobe tables.
module tb_mvau_weight_loader;

  logic aclk   = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  // Instance 0: defaults (SIMD=2, TW=1, PE=2, DEPTH=4, ABW=4)
  logic       s0 = 1'b0, v0 = 1'b0;
  logic [1:0] w0 = '0;
  logic       rdy0, busy0, done0;
  logic [1:0] we0;
  logic [3:0] ad0;
  logic [1:0] wd0;

  // Instance 1: SIMD=4, TW=2, PE=1, DEPTH=3, ABW=2
  logic       s1 = 1'b0, v1 = 1'b0;
  logic [7:0] w1 = '0;
  logic       rdy1, busy1, done1;
  logic [0:0] we1;
  logic [1:0] ad1;
  logic [7:0] wd1;

  mvau_weight_loader u_dut0 (
    .aclk(aclk), .areset(areset), .start(s0), .in_v(v0), .in_wgt(w0), .in_rdy(rdy0),
    .wmem_we(we0), .wmem_addr(ad0), .wmem_wdata(wd0), .busy(busy0), .done(done0)
  );

  mvau_weight_loader #(
    .SIMD(4), .TW(2), .PE(1), .WMEM_DEPTH(3), .WMEM_ADDR_BW(2)
  ) u_dut1 (
    .aclk(aclk), .areset(areset), .start(s1), .in_v(v1), .in_wgt(w1), .in_rdy(rdy1),
    .wmem_we(we1), .wmem_addr(ad1), .wmem_wdata(wd1), .busy(busy1), .done(done1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a load is just a count k of accepted beats; beat k -> bank k%PE, address k/PE.
  int pen[2] = '{2, 1};
  int dep[2] = '{4, 3};
  bit m_load[2];
  bit m_done[2];
  bit m_armed[2];
  int m_k[2];
  int m_we[2];
  int m_addr[2];
  int m_data[2];

  task automatic model_reset(input int d);
    m_load[d] = 0; m_done[d] = 0; m_armed[d] = 0; m_k[d] = 0;
    m_we[d] = 0; m_addr[d] = 0; m_data[d] = 0;
  endtask

  task automatic model_step(input int d, input logic st, input logic v, input int w);
    bit was_idle;
    was_idle  = !m_load[d] && !m_done[d];
    m_done[d] = 0;
    m_we[d]   = 0;
    if (m_load[d] && v) begin
      m_we[d]   = 1 << (m_k[d] % pen[d]);
      m_addr[d] = m_k[d] / pen[d];
      m_data[d] = w;
      m_k[d]++;
      if (m_k[d] == pen[d] * dep[d]) begin
        m_load[d] = 0;
        m_done[d] = 1;
      end
    end
    if (was_idle && st && m_armed[d]) begin
      m_load[d] = 1;
      m_k[d]    = 0;
    end
    m_armed[d] = 1;
  endtask

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, s0, v0, int'(w0));
      model_step(1, s1, v1, int'(w1));
    end
  end

  // Strobe logs for the hand-computed tables
  int lw0[$], la0[$], ld0[$], ldn0[$];
  int lw1[$], la1[$], ld1[$], ldn1[$];
  int busy_cnt0 = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;

  always @(negedge aclk) begin
    check("rdy0", int'(rdy0), int'(m_load[0]));
    check("busy0", int'(busy0), int'(m_load[0]));
    check("done0", int'(done0), int'(m_done[0]));
    check("we0", int'(we0), m_we[0]);
    check("addr0", int'(ad0), m_addr[0]);
    check("wdata0", int'(wd0), m_data[0]);
    check("rdy1", int'(rdy1), int'(m_load[1]));
    check("busy1", int'(busy1), int'(m_load[1]));
    check("done1", int'(done1), int'(m_done[1]));
    check("we1", int'(we1), m_we[1]);
    check("addr1", int'(ad1), m_addr[1]);
    check("wdata1", int'(wd1), m_data[1]);
    if (we0 != 0) begin
      lw0.push_back(int'(we0)); la0.push_back(int'(ad0));
      ld0.push_back(int'(wd0)); ldn0.push_back(int'(done0));
    end
    if (we1 != 0) begin
      lw1.push_back(int'(we1)); la1.push_back(int'(ad1));
      ld1.push_back(int'(wd1)); ldn1.push_back(int'(done1));
    end
    if (busy0) busy_cnt0++;
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
  end

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic clear_logs();
    lw0.delete(); la0.delete(); ld0.delete(); ldn0.delete();
    lw1.delete(); la1.delete(); ld1.delete(); ldn1.delete();
    busy_cnt0 = 0; done_cnt0 = 0; done_cnt1 = 0;
  endtask

  // Expected full-load table for instance 0 with data k%4.
  task automatic check_log0(input string name);
    check({name, "_strobes"}, lw0.size(), 8);
    check({name, "_done_cnt"}, done_cnt0, 1);
    for (int i = 0; i < lw0.size() && i < 8; i++) begin
      check({name, "_we"}, lw0[i], (i % 2 == 0) ? 1 : 2);
      check({name, "_addr"}, la0[i], i / 2);
      check({name, "_data"}, ld0[i], i % 4);
      check({name, "_done_with"}, ldn0[i], (i == 7) ? 1 : 0);
    end
  endtask

  task automatic beats0(input int first, input int n, input int gap);
    for (int k = first; k < first + n; k++) begin
      v0 = 1'b1;
      w0 = 2'(k % 4);
      tick();
      v0 = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic start0();
    s0 = 1'b1;
    tick();
    s0 = 1'b0;
  endtask

  int data1[3] = '{8'hA5, 8'h5A, 8'hFF};

  initial begin
    // Start coinciding with reset release must be ignored
    #12;
    s0 = 1'b1;
    areset = 1'b0;
    tick();
    s0 = 1'b0;
    tick();
    check("release_start_ignored", int'(busy0), 0);

    // Basic back-to-back load
    clear_logs();
    start0();
    beats0(0, 8, 0);
    tick(); tick();
    check_log0("basic");
    check("basic_busy_cycles", busy_cnt0, 8);

    // Stalled stream: in_v 1,0,0,...
    clear_logs();
    start0();
    beats0(0, 8, 2);
    tick();
    check_log0("stall");

    // in_v held high in IDLE and after DONE
    clear_logs();
    v0 = 1'b1;
    tick(); tick();
    check("idle_rdy", int'(rdy0), 0);
    s0 = 1'b1;
    tick();
    s0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      w0 = 2'(k % 4);
      tick();
    end
    for (int k = 0; k < 4; k++) tick();
    v0 = 1'b0;
    tick();
    check_log0("reject");

    // Start pulsed mid-load must not restart counters
    clear_logs();
    start0();
    beats0(0, 3, 0);
    s0 = 1'b1;
    tick();
    s0 = 1'b0;
    beats0(3, 5, 0);
    tick();
    check_log0("midstart");
    if (lw0.size() > 3) begin
      check("midstart_beat4_we", lw0[3], 2);
      check("midstart_beat4_addr", la0[3], 1);
    end

    // Async reset after beat 5, then a clean restart
    clear_logs();
    start0();
    beats0(0, 5, 0);
    areset = 1'b1;
    #1;
    check("rst_rdy", int'(rdy0), 0);
    check("rst_we", int'(we0), 0);
    check("rst_addr", int'(ad0), 0);
    check("rst_wdata", int'(wd0), 0);
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    tick();
    areset = 1'b0;
    tick();
    clear_logs();
    start0();
    beats0(0, 8, 0);
    tick();
    check_log0("restart");

    // PE=1 sweep instance
    clear_logs();
    s1 = 1'b1;
    tick();
    s1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      v1 = 1'b1;
      w1 = 8'(data1[k]);
      tick();
    end
    v1 = 1'b0;
    tick(); tick();
    check("pe1_strobes", lw1.size(), 3);
    check("pe1_done_cnt", done_cnt1, 1);
    for (int i = 0; i < lw1.size() && i < 3; i++) begin
      check("pe1_we", lw1[i], 1);
      check("pe1_addr", la1[i], i);
      check("pe1_data", ld1[i], data1[i]);
      check("pe1_done_with", ldn1[i], (i == 2) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
